// File: rtl/axi_lite_pkg.sv
// -----------------------------------------------------------------------------
// axi_lite_pkg
// Shared definitions for the AXI4-Lite register bank: response codes, the
// write/read FSM state encodings, the decode result type, an address-decode
// helper and a byte-strobe merge helper.
// -----------------------------------------------------------------------------
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Index is wide enough for the largest supported bank (256 words).
    localparam int unsigned IDX_W = 8;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wstate_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_e;

    typedef struct packed {
        logic             hit;
        logic [IDX_W-1:0] index;
    } decode_t;

    // Range, alignment and bound check. All values are zero-extended to 64
    // bits by the caller; the offset is then truncated to addr_w bits. The
    // range check rejects anything below base before the index is trusted,
    // so a wrapped offset can never alias onto a real register.
    function automatic decode_t decode_addr(
        input logic [63:0] addr,
        input logic [63:0] base,
        input logic [63:0] high,
        input int unsigned num_regs,
        input int unsigned addr_w
    );
        logic [63:0] mask;
        logic [63:0] offset;
        logic [63:0] word;
        decode_t     d;
        mask    = (addr_w >= 32'd64) ? {64{1'b1}} : ((64'd1 << addr_w) - 64'd1);
        offset  = (addr - base) & mask;
        word    = offset >> 2;
        d.hit   = (addr >= base) && (addr <= high) && (addr[1:0] == 2'b00) &&
                  (word < 64'(num_regs));
        d.index = offset[IDX_W+1:2];
        return d;
    endfunction

    // Byte-lane merge: lane b takes the new byte where strb[b] is set.
    function automatic logic [31:0] apply_wstrb(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_lite_regbank_decode.sv
// -----------------------------------------------------------------------------
// axi_lite_regbank_decode
// Combinational address check for one AXI channel.
// Ports:
//   addr  - byte address presented on the channel
//   hit   - address is in range, word aligned and below C_NUM_REGS
//   index - word index relative to C_BASE (meaningful only when hit=1)
// -----------------------------------------------------------------------------
module axi_lite_regbank_decode
    import axi_lite_pkg::*;
#(
    parameter int unsigned               C_ADDR_WIDTH = 32,
    parameter logic [C_ADDR_WIDTH-1:0]   C_BASE       = 32'h0000_0000,
    parameter logic [C_ADDR_WIDTH-1:0]   C_HIGH       = 32'h0000_FFFF,
    parameter int unsigned               C_NUM_REGS   = 8
) (
    input  logic [C_ADDR_WIDTH-1:0] addr,
    output logic                    hit,
    output logic [IDX_W-1:0]        index
);

    decode_t dec_s;

    // Evaluate the shared decode rule on this channel's address.
    always_comb begin
        dec_s = decode_addr(64'(addr), 64'(C_BASE), 64'(C_HIGH), C_NUM_REGS, C_ADDR_WIDTH);
        hit   = dec_s.hit;
        index = dec_s.index;
    end

endmodule

// File: rtl/axi_lite_regbank.sv
// -----------------------------------------------------------------------------
// axi_lite_regbank
// AXI4-Lite slave register bank with C_NUM_REGS 32-bit words. Words whose
// C_RO_MASK bit is set are read-only and return the matching STATUS_IN word.
// Independent write and read FSMs; byte-strobe writes; SLVERR on out-of-range,
// misaligned or read-only-target accesses; one-cycle WR_PULSE per commit.
// Ports:
//   ACLK, ARESETN        - clock, async active-low reset
//   S_AXI_AW*/W*/B*      - write address / data / response channels
//   S_AXI_AR*/R*         - read address / data channels
//   REG_OUT              - flattened stored register values, word i at [32i+:32]
//   STATUS_IN            - flattened status words, used for read-only indices
//   WR_PULSE             - bit i high for one cycle after register i is written
// -----------------------------------------------------------------------------
module axi_lite_regbank
    import axi_lite_pkg::*;
#(
    parameter int unsigned                     C_S_AXI_ADDR_WIDTH = 32,
    parameter int unsigned                     C_S_AXI_DATA_WIDTH = 32,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0]   C_S_AXI_BASE_ADDR  = 32'h0000_0000,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0]   C_S_AXI_HIGH_ADDR  = 32'h0000_FFFF,
    parameter int unsigned                     C_NUM_REGS         = 8,
    parameter logic [C_NUM_REGS-1:0]           C_RO_MASK          = {C_NUM_REGS{1'b0}},
    parameter logic [31:0]                     C_RST_VAL          = 32'h0000_0000
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [32*C_NUM_REGS-1:0]          REG_OUT,
    input  logic [32*C_NUM_REGS-1:0]          STATUS_IN,
    output logic [C_NUM_REGS-1:0]             WR_PULSE
);

    generate
        if (C_S_AXI_DATA_WIDTH != 32) begin : g_bad_data_width
            $error("axi_lite_regbank supports only a 32-bit data bus");
        end
        if ((C_NUM_REGS < 1) || (C_NUM_REGS > 256)) begin : g_bad_num_regs
            $error("axi_lite_regbank C_NUM_REGS must be in 1..256");
        end
    endgenerate

    // Protection attributes carry no meaning for this bank.
    logic unused_s;
    assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    // ---------------- state ----------------
    wstate_e                 wstate_r, wstate_n;
    logic                    awready_r, awready_n;
    logic                    wready_r, wready_n;
    logic                    aw_cap_r, aw_cap_n;
    logic                    w_cap_r, w_cap_n;
    logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_r, aw_addr_n;
    logic [31:0]             wdata_r, wdata_n;
    logic [3:0]              wstrb_r, wstrb_n;
    logic                    bvalid_r, bvalid_n;
    logic [1:0]              bresp_r, bresp_n;

    rstate_e                 rstate_r, rstate_n;
    logic                    arready_r, arready_n;
    logic                    rvalid_r, rvalid_n;
    logic [31:0]             rdata_r, rdata_n;
    logic [1:0]              rresp_r, rresp_n;

    logic [31:0]             regs_r [C_NUM_REGS];
    logic [C_NUM_REGS-1:0]   wr_pulse_r;

    // ---------------- combinational helpers ----------------
    logic                          aw_hs_s, w_hs_s, ar_hs_s, commit_s;
    logic [C_S_AXI_ADDR_WIDTH-1:0] wr_addr_s;
    logic [31:0]                   wr_data_s;
    logic [3:0]                    wr_strb_s;
    logic                          wr_hit_s, rd_hit_s, wr_ro_s, wr_ok_s;
    logic [IDX_W-1:0]              wr_idx_s, rd_idx_s;
    logic [C_NUM_REGS-1:0]         wr_sel_s;
    logic [31:0]                   rd_word_s;

    assign aw_hs_s = S_AXI_AWVALID && awready_r;
    assign w_hs_s  = S_AXI_WVALID  && wready_r;
    assign ar_hs_s = S_AXI_ARVALID && arready_r;

    // A channel captured on an earlier edge supplies its held value; one
    // handshaking on this edge is bypassed so the commit needs no extra cycle.
    assign wr_addr_s = aw_cap_r ? aw_addr_r : S_AXI_AWADDR;
    assign wr_data_s = w_cap_r  ? wdata_r   : S_AXI_WDATA;
    assign wr_strb_s = w_cap_r  ? wstrb_r   : S_AXI_WSTRB;

    axi_lite_regbank_decode #(
        .C_ADDR_WIDTH (C_S_AXI_ADDR_WIDTH),
        .C_BASE       (C_S_AXI_BASE_ADDR),
        .C_HIGH       (C_S_AXI_HIGH_ADDR),
        .C_NUM_REGS   (C_NUM_REGS)
    ) u_wr_decode (
        .addr  (wr_addr_s),
        .hit   (wr_hit_s),
        .index (wr_idx_s)
    );

    axi_lite_regbank_decode #(
        .C_ADDR_WIDTH (C_S_AXI_ADDR_WIDTH),
        .C_BASE       (C_S_AXI_BASE_ADDR),
        .C_HIGH       (C_S_AXI_HIGH_ADDR),
        .C_NUM_REGS   (C_NUM_REGS)
    ) u_rd_decode (
        .addr  (S_AXI_ARADDR),
        .hit   (rd_hit_s),
        .index (rd_idx_s)
    );

    // One-hot write target, read-only qualification and read data mux.
    always_comb begin
        wr_sel_s  = {C_NUM_REGS{1'b0}};
        rd_word_s = 32'h0000_0000;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            wr_sel_s[i] = wr_hit_s && (wr_idx_s == IDX_W'(i));
            rd_word_s   = rd_word_s |
                          ((rd_hit_s && (rd_idx_s == IDX_W'(i))) ?
                           (C_RO_MASK[i] ? STATUS_IN[32*i +: 32] : regs_r[i]) : 32'h0000_0000);
        end
        wr_ro_s = |(wr_sel_s & C_RO_MASK);
        wr_ok_s = wr_hit_s && !wr_ro_s;
    end

    // Write FSM next-state and output logic.
    always_comb begin
        wstate_n  = wstate_r;
        awready_n = awready_r;
        wready_n  = wready_r;
        aw_cap_n  = aw_cap_r;
        w_cap_n   = w_cap_r;
        aw_addr_n = aw_addr_r;
        wdata_n   = wdata_r;
        wstrb_n   = wstrb_r;
        bvalid_n  = bvalid_r;
        bresp_n   = bresp_r;
        commit_s  = 1'b0;
        case (wstate_r)
            W_IDLE: begin
                if (aw_hs_s) begin
                    aw_cap_n  = 1'b1;
                    aw_addr_n = S_AXI_AWADDR;
                    awready_n = 1'b0;
                end else begin
                    awready_n = !aw_cap_r;
                end
                if (w_hs_s) begin
                    w_cap_n  = 1'b1;
                    wdata_n  = S_AXI_WDATA;
                    wstrb_n  = S_AXI_WSTRB;
                    wready_n = 1'b0;
                end else begin
                    wready_n = !w_cap_r;
                end
                if ((aw_cap_r || aw_hs_s) && (w_cap_r || w_hs_s)) begin
                    commit_s  = 1'b1;
                    wstate_n  = W_RESP;
                    bvalid_n  = 1'b1;
                    bresp_n   = wr_ok_s ? RESP_OKAY : RESP_SLVERR;
                    awready_n = 1'b0;
                    wready_n  = 1'b0;
                    aw_cap_n  = 1'b0;
                    w_cap_n   = 1'b0;
                end else begin
                    commit_s  = 1'b0;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    wstate_n  = W_IDLE;
                    bvalid_n  = 1'b0;
                    awready_n = 1'b1;
                    wready_n  = 1'b1;
                end else begin
                    bvalid_n  = 1'b1;
                    awready_n = 1'b0;
                    wready_n  = 1'b0;
                end
            end
            default: begin
                wstate_n  = W_IDLE;
                bvalid_n  = 1'b0;
                awready_n = 1'b0;
                wready_n  = 1'b0;
                aw_cap_n  = 1'b0;
                w_cap_n   = 1'b0;
            end
        endcase
    end

    // Read FSM next-state and output logic.
    always_comb begin
        rstate_n  = rstate_r;
        arready_n = arready_r;
        rvalid_n  = rvalid_r;
        rdata_n   = rdata_r;
        rresp_n   = rresp_r;
        case (rstate_r)
            R_IDLE: begin
                if (ar_hs_s) begin
                    rstate_n  = R_DATA;
                    arready_n = 1'b0;
                    rvalid_n  = 1'b1;
                    rdata_n   = rd_word_s;
                    rresp_n   = rd_hit_s ? RESP_OKAY : RESP_SLVERR;
                end else begin
                    arready_n = 1'b1;
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    rstate_n  = R_IDLE;
                    rvalid_n  = 1'b0;
                    arready_n = 1'b1;
                end else begin
                    rvalid_n  = 1'b1;
                    arready_n = 1'b0;
                end
            end
            default: begin
                rstate_n  = R_IDLE;
                rvalid_n  = 1'b0;
                arready_n = 1'b0;
            end
        endcase
    end

    // Write FSM state and channel registers.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wstate_r  <= W_IDLE;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            aw_cap_r  <= 1'b0;
            w_cap_r   <= 1'b0;
            aw_addr_r <= {C_S_AXI_ADDR_WIDTH{1'b0}};
            wdata_r   <= 32'h0000_0000;
            wstrb_r   <= 4'h0;
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
        end else begin
            wstate_r  <= wstate_n;
            awready_r <= awready_n;
            wready_r  <= wready_n;
            aw_cap_r  <= aw_cap_n;
            w_cap_r   <= w_cap_n;
            aw_addr_r <= aw_addr_n;
            wdata_r   <= wdata_n;
            wstrb_r   <= wstrb_n;
            bvalid_r  <= bvalid_n;
            bresp_r   <= bresp_n;
        end
    end

    // Read FSM state and channel registers.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rstate_r  <= R_IDLE;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= 32'h0000_0000;
            rresp_r   <= RESP_OKAY;
        end else begin
            rstate_r  <= rstate_n;
            arready_r <= arready_n;
            rvalid_r  <= rvalid_n;
            rdata_r   <= rdata_n;
            rresp_r   <= rresp_n;
        end
    end

    // Register storage and the per-register write pulse.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                regs_r[i] <= C_RST_VAL;
            end
            wr_pulse_r <= {C_NUM_REGS{1'b0}};
        end else begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                if (commit_s && wr_ok_s && wr_sel_s[i]) begin
                    regs_r[i] <= apply_wstrb(regs_r[i], wr_data_s, wr_strb_s);
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
            wr_pulse_r <= (commit_s && wr_ok_s) ? wr_sel_s : {C_NUM_REGS{1'b0}};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < C_NUM_REGS; gi++) begin : g_reg_out
            assign REG_OUT[32*gi +: 32] = regs_r[gi];
        end
    endgenerate

    assign S_AXI_AWREADY = awready_r;
    assign S_AXI_WREADY  = wready_r;
    assign S_AXI_BVALID  = bvalid_r;
    assign S_AXI_BRESP   = bresp_r;
    assign S_AXI_ARREADY = arready_r;
    assign S_AXI_RVALID  = rvalid_r;
    assign S_AXI_RDATA   = rdata_r;
    assign S_AXI_RRESP   = rresp_r;
    assign WR_PULSE      = wr_pulse_r;

endmodule

// File: tb/tb_axi_lite_regbank.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_regbank
// Scoreboard bench: stimulus predicts every B and R response from an array
// model of the bank and queues it; two monitors compare what the DUT presents.
// -----------------------------------------------------------------------------
module tb_axi_lite_regbank;

    localparam logic [31:0] BASE    = 32'h43C0_0000;
    localparam logic [31:0] HIGH    = 32'h43C0_FFFF;
    localparam int          N       = 8;
    localparam logic [7:0]  RO_MASK = 8'b0000_1000;
    localparam logic [31:0] RST     = 32'h0000_0000;

    typedef struct { logic [1:0] resp; logic [7:0] pulse; logic [255:0] snap; } bexp_t;
    typedef struct { logic [31:0] data; logic [1:0] resp; } rexp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  awaddr = 32'h0, wdata = 32'h0, araddr = 32'h0;
    logic [2:0]   awprot = 3'h0, arprot = 3'h0;
    logic [3:0]   wstrb = 4'h0;
    logic         awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic         bready = 1'b1, rready = 1'b1;
    logic         awready, wready, bvalid, arready, rvalid;
    logic [1:0]   bresp, rresp;
    logic [31:0]  rdata;
    logic [255:0] reg_out;
    logic [255:0] status_in;
    logic [7:0]   wr_pulse;

    int           n_cmp = 0;
    int           n_fail = 0;
    logic [31:0]  model [N];
    logic [7:0]   ro_v = RO_MASK;
    bexp_t        bq[$];
    rexp_t        rq[$];
    logic         b_prev = 1'b0;

    axi_lite_regbank #(
        .C_S_AXI_ADDR_WIDTH (32),
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_BASE_ADDR  (BASE),
        .C_S_AXI_HIGH_ADDR  (HIGH),
        .C_NUM_REGS         (N),
        .C_RO_MASK          (RO_MASK),
        .C_RST_VAL          (RST)
    ) dut (
        .ACLK (clk), .ARESETN (rst_n),
        .S_AXI_AWADDR (awaddr), .S_AXI_AWPROT (awprot), .S_AXI_AWVALID (awvalid), .S_AXI_AWREADY (awready),
        .S_AXI_WDATA (wdata), .S_AXI_WSTRB (wstrb), .S_AXI_WVALID (wvalid), .S_AXI_WREADY (wready),
        .S_AXI_BRESP (bresp), .S_AXI_BVALID (bvalid), .S_AXI_BREADY (bready),
        .S_AXI_ARADDR (araddr), .S_AXI_ARPROT (arprot), .S_AXI_ARVALID (arvalid), .S_AXI_ARREADY (arready),
        .S_AXI_RDATA (rdata), .S_AXI_RRESP (rresp), .S_AXI_RVALID (rvalid), .S_AXI_RREADY (rready),
        .REG_OUT (reg_out), .STATUS_IN (status_in), .WR_PULSE (wr_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out", nm);
    endtask

    // Reference decode: range, word alignment and bank size.
    function automatic bit m_decode(input logic [31:0] a, output int idx);
        longint unsigned off;
        idx = 0;
        if (a < BASE || a > HIGH || a[1:0] != 2'b00) return 1'b0;
        off = longint'(a) - longint'(BASE);
        idx = int'(off / 4);
        return idx < N;
    endfunction

    function automatic logic [255:0] snapshot();
        logic [255:0] s;
        for (int i = 0; i < N; i++) s[32*i +: 32] = model[i];
        return s;
    endfunction

    task automatic predict_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int    idx;
        bit    ok;
        bexp_t e;
        ok = m_decode(a, idx) && !ro_v[idx];
        e.pulse = 8'h00;
        e.resp  = ok ? 2'b00 : 2'b10;
        if (ok) begin
            for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
            e.pulse[idx] = 1'b1;
        end
        e.snap = snapshot();
        bq.push_back(e);
    endtask

    task automatic predict_read(input logic [31:0] a);
        int    idx;
        rexp_t e;
        if (m_decode(a, idx)) begin
            e.resp = 2'b00;
            e.data = ro_v[idx] ? status_in[32*idx +: 32] : model[idx];
        end else begin
            e.resp = 2'b10;
            e.data = 32'h0;
        end
        rq.push_back(e);
    endtask

    // which: 0 AWREADY, 1 WREADY, 2 ARREADY, 3 B handshake, 4 R handshake
    task automatic wait_ev(input int which, input string nm);
        bit done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            case (which)
                0: done = awready;
                1: done = wready;
                2: done = arready;
                3: done = bvalid && bready;
                4: done = rvalid && rready;
                default: done = 1'b1;
            endcase
            @(posedge clk); #1;
        end
        if (!done) timeout_fail(nm);
    endtask

    task automatic drive_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                               input int aw_dly, input int w_dly, input int bstall);
        if (bstall > 0) bready = 1'b0;
        fork
            begin
                for (int k = 0; k < aw_dly; k++) begin
                    @(negedge clk); chk("no_bvalid_before_aw", bvalid, 1'b0);
                    @(posedge clk); #1;
                end
                awaddr = a; awprot = 3'($urandom_range(0, 7)); awvalid = 1'b1;
                wait_ev(0, "aw_handshake");
                awvalid = 1'b0; awaddr = $urandom;
            end
            begin
                for (int k = 0; k < w_dly; k++) begin @(posedge clk); #1; end
                wdata = d; wstrb = s; wvalid = 1'b1;
                wait_ev(1, "w_handshake");
                wvalid = 1'b0; wdata = $urandom;
            end
        join
        chk("bvalid_latency", bvalid, 1'b1);
        if (bstall > 0) begin
            for (int k = 0; k < bstall; k++) begin @(posedge clk); #1; end
            bready = 1'b1;
        end
        wait_ev(3, "b_handshake");
    endtask

    task automatic drive_read(input logic [31:0] a, input int rstall);
        if (rstall > 0) rready = 1'b0;
        araddr = a; arprot = 3'($urandom_range(0, 7)); arvalid = 1'b1;
        wait_ev(2, "ar_handshake");
        arvalid = 1'b0; araddr = $urandom;
        chk("rvalid_latency", rvalid, 1'b1);
        if (rstall > 0) begin
            for (int k = 0; k < rstall; k++) begin @(posedge clk); #1; end
            rready = 1'b1;
        end
        wait_ev(4, "r_handshake");
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5, 6: return BASE + 32'(4 * $urandom_range(0, 9));
            7:       return BASE + 32'($urandom_range(0, 40));
            8:       return BASE - 32'(4 * $urandom_range(1, 4));
            default: return $urandom;
        endcase
    endfunction

    // Write-response monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bvalid) begin
                if (bq.size() == 0) begin
                    timeout_fail("unexpected_bvalid");
                end else begin
                    if (!b_prev) begin
                        chk("wr_pulse", wr_pulse, bq[0].pulse);
                        chk("reg_out", reg_out, bq[0].snap);
                    end else begin
                        chk("wr_pulse_one_cycle", wr_pulse, 8'h00);
                    end
                    chk("bresp", bresp, bq[0].resp);
                    chk("aw_w_ready_low_in_resp", {awready, wready}, 2'b00);
                    if (bready) void'(bq.pop_front());
                end
            end else begin
                chk("wr_pulse_idle", wr_pulse, 8'h00);
            end
        end
        b_prev <= bvalid;
    end

    // Read-data monitor.
    always @(negedge clk) begin
        if (rst_n && rvalid) begin
            if (rq.size() == 0) begin
                timeout_fail("unexpected_rvalid");
            end else begin
                chk("rdata", rdata, rq[0].data);
                chk("rresp", rresp, rq[0].resp);
                chk("arready_low_in_data", arready, 1'b0);
                if (rready) void'(rq.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, d;
        logic [3:0]  s;
        for (int i = 0; i < N; i++) begin
            model[i] = RST;
            status_in[32*i +: 32] = $urandom;
        end
        status_in[96 +: 32] = 32'hCAFE_0003;

        // Reset state and ready rise on the first edge after release.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_readies", {awready, wready, arready}, 3'b000);
        chk("reset_valids", {bvalid, rvalid}, 2'b00);
        chk("reset_resp_data", {bresp, rresp, rdata}, 36'h0);
        chk("reset_reg_out", reg_out, snapshot());
        chk("reset_wr_pulse", wr_pulse, 8'h00);
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        chk("readies_before_first_edge", {awready, wready, arready}, 3'b000);
        @(posedge clk); #1;
        chk("readies_after_first_edge", {awready, wready, arready}, 3'b111);

        // Full-word write with AW and W together, then readback.
        predict_write(BASE + 32'h4, 32'hDEAD_BEEF, 4'hF);
        drive_write(BASE + 32'h4, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
        predict_read(BASE + 32'h4);
        drive_read(BASE + 32'h4, 0);

        // W three cycles ahead of AW, partial strobe.
        predict_write(BASE + 32'h8, 32'h1122_3344, 4'b0101);
        drive_write(BASE + 32'h8, 32'h1122_3344, 4'b0101, 3, 0, 0);
        chk("reg2_strobed", reg_out[64 +: 32], 32'h0022_0044);
        predict_read(BASE + 32'h8);
        drive_read(BASE + 32'h8, 0);

        // Read-only register: write rejected, read returns status.
        predict_write(BASE + 32'hC, 32'h1234_5678, 4'hF);
        drive_write(BASE + 32'hC, 32'h1234_5678, 4'hF, 0, 1, 0);
        predict_read(BASE + 32'hC);
        drive_read(BASE + 32'hC, 0);

        // Out-of-bank index, misaligned read, out-of-bank write, below base.
        predict_read(BASE + 32'h20);  drive_read(BASE + 32'h20, 0);
        predict_read(BASE + 32'h6);   drive_read(BASE + 32'h6, 0);
        predict_write(BASE + 32'h20, 32'hFFFF_FFFF, 4'hF);
        drive_write(BASE + 32'h20, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        predict_read(BASE - 32'h4);   drive_read(BASE - 32'h4, 0);

        // Back-pressure on both response channels, running concurrently.
        predict_write(BASE + 32'h10, 32'hA5A5_5A5A, 4'hF);
        predict_read(BASE + 32'h4);
        fork
            drive_write(BASE + 32'h10, 32'hA5A5_5A5A, 4'hF, 0, 0, 5);
            drive_read(BASE + 32'h4, 5);
        join

        // Read and write to the same register on the same edge.
        predict_read(BASE + 32'h4);
        predict_write(BASE + 32'h4, 32'h0BAD_F00D, 4'hF);
        fork
            drive_write(BASE + 32'h4, 32'h0BAD_F00D, 4'hF, 0, 0, 0);
            drive_read(BASE + 32'h4, 0);
        join

        // Randomized mix.
        for (int k = 0; k < 80; k++) begin
            a = rand_addr();
            if ($urandom_range(0, 3) == 0) status_in[96 +: 32] = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                predict_write(a, d, s);
                drive_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            end else begin
                predict_read(a);
                drive_read(a, $urandom_range(0, 2));
            end
        end

        // Reset while both responses are pending.
        predict_write(BASE + 32'h8, 32'h5A5A_5A5A, 4'hF);
        predict_read(BASE + 32'hC);
        bready = 1'b0; rready = 1'b0;
        awaddr = BASE + 32'h8; wdata = 32'h5A5A_5A5A; wstrb = 4'hF; araddr = BASE + 32'hC;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(posedge clk); #3;
        chk("pending_before_reset", {bvalid, rvalid}, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("async_reset_readies", {awready, wready, arready}, 3'b000);
        chk("async_reset_valids", {bvalid, rvalid}, 2'b00);
        chk("async_reset_resp_data", {bresp, rresp, rdata}, 36'h0);
        chk("async_reset_wr_pulse", wr_pulse, 8'h00);
        bq.delete(); rq.delete();
        for (int i = 0; i < N; i++) model[i] = RST;
        chk("async_reset_reg_out", reg_out, snapshot());
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1; bready = 1'b1; rready = 1'b1;
        @(posedge clk); #1;
        chk("readies_after_reset_release", {awready, wready, arready}, 3'b111);

        // New traffic after the reset.
        predict_write(BASE, 32'h7654_3210, 4'b1100);
        drive_write(BASE, 32'h7654_3210, 4'b1100, 1, 0, 0);
        predict_read(BASE);
        drive_read(BASE, 0);
        predict_read(BASE + 32'h8);
        drive_read(BASE + 32'h8, 0);

        repeat (5) @(posedge clk);
        #1;
        chk("b_queue_drained", 256'(bq.size()), 256'd0);
        chk("r_queue_drained", 256'(rq.size()), 256'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_lite_regbank.md
Name: axi_lite_regbank

Overview:
Parametrised AXI4-Lite slave register bank. It provides C_NUM_REGS 32-bit word registers; a read-only mask selects which words reflect live status inputs instead of stored values. It has independent write and read state machines, byte-strobe writes, address-range and alignment checking with SLVERR, and per-register write pulses toward user logic. It is the standard control/status front end for pcores on the AXI interconnect.

Parameters:
C_S_AXI_BASE_ADDR, 32'h0000_0000, byte base address of the bank
C_S_AXI_HIGH_ADDR, 32'h0000_FFFF, last byte address decoded by the interconnect
C_S_AXI_ADDR_WIDTH, 32, AXI address width
C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported, enforced by an elaboration-time check
C_NUM_REGS, 8, number of word registers, range 1..256
C_RO_MASK, 0 (C_NUM_REGS bits), bit i=1 makes register i read-only, sourced from STATUS_IN word i
C_RST_VAL, 0, reset value loaded into every writable register

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset; asserted asynchronously, deasserted synchronously to ACLK upstream
S_AXI_AWADDR/AWPROT/AWVALID/AWREADY  in/in/in/out  ADDR_WIDTH/3/1/1  write address channel
S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  32/4/1/1  write data channel
S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel
S_AXI_ARADDR/ARPROT/ARVALID/ARREADY  in/in/in/out  ADDR_WIDTH/3/1/1  read address channel
S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  32/2/1/1  read data channel
REG_OUT  out  32*C_NUM_REGS  flattened current register values; word i at bits [32i+31:32i]
STATUS_IN  in  32*C_NUM_REGS  flattened status words; only RO indices are used
WR_PULSE  out  C_NUM_REGS  one-cycle strobe on the cycle after register i commits a write

Behaviour:
- Reset values: all AXI outputs (READYs, BVALID, RVALID, BRESP, RRESP, RDATA) are 0; REG_OUT equals C_RST_VAL; WR_PULSE is 0.
- All outputs are registered. AWREADY, WREADY and ARREADY rise on the first clock edge after ARESETN deasserts.
- Decode:
  - offset = addr - BASE; index = offset>>2.
  - A valid hit requires BASE <= addr <= HIGH, index < C_NUM_REGS, and addr[1:0] == 0.
  - AxPROT is ignored.
- Write FSM, states W_IDLE → W_RESP:
  - In W_IDLE, the AW and W handshakes are accepted independently, in either order or the same cycle.
  - Each ready drops in the cycle after its handshake, and the captured address/data/strobe are held.
  - The commit happens on the edge where both AW and W are captured; the FSM then moves to W_RESP with BVALID=1.
  - A commit updates register[index] byte-wise: byte b is written where WSTRB[b]=1.
  - Invalid hit or RO target: no update, no pulse, BRESP=2'b10 (SLVERR). Otherwise BRESP=2'b00.
  - BVALID and BRESP are held until BREADY. On the B handshake the FSM returns to W_IDLE with AWREADY=WREADY=1 in the following cycle.
  - Minimum latency: BVALID asserts one cycle after the later of the AW and W handshakes.
- Read FSM, states R_IDLE → R_DATA:
  - ARREADY=1 in R_IDLE. On the AR handshake, RDATA is loaded from register[index] (or STATUS_IN[index] if RO), and RVALID=1 in the next cycle with ARREADY=0.
  - Invalid hit: RDATA=32'h0, RRESP=2'b10.
  - RDATA, RRESP and RVALID are held until RREADY, then the FSM returns to R_IDLE with ARREADY=1 the following cycle.
- Simultaneous events:
  - A read handshake on the same edge as a write commit to the same register returns the pre-write value.
  - Read and write FSMs run concurrently and do not stall each other.
- Wrap/overflow: offset arithmetic uses ADDR_WIDTH bits. An address below BASE fails the range check before index use, so no aliasing is possible.
- Reset mid-transaction: both FSMs return to idle immediately. Pending responses are discarded and registers reload C_RST_VAL.

Decomposition:
- Shared package axi_lite_pkg holds:
  - response codes RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - FSM state encodings
  - a function computing the valid-hit flag and index from the address
- One natural sub-module: axi_lite_regbank_decode, a combinational address check → {hit, index}, instantiated once per channel.

Test Plan:
- Reset, then write 0x43C0_0004 ← 0xDEADBEEF with WSTRB=4'hF, AW and W in the same cycle → BRESP=00 one cycle later, WR_PULSE[1]=1 for one cycle, REG_OUT word1=0xDEADBEEF; readback returns 0xDEADBEEF with RRESP=00.
- W presented 3 cycles before AW to reg2 with data 0x11223344, WSTRB=4'b0101, previous value 0 → reg2=0x00220044; BVALID only after AW accepted.
- With C_RO_MASK bit3=1 and STATUS_IN word3=0xCAFE0003: write reg3 → SLVERR, no WR_PULSE; read reg3 → 0xCAFE0003, RRESP=00.
- Read offset 0x20 (index 8 with C_NUM_REGS=8) and misaligned 0x06 → RDATA=0, RRESP=10; write to 0x20 → BRESP=10, no register changes.
- Hold BREADY=0 and RREADY=0 for 5 cycles → BVALID/RVALID and data stable, AWREADY/WREADY/ARREADY stay 0 until the handshakes complete.
- Assert ARESETN low while BVALID=1 and RVALID=1 → all outputs 0 asynchronously, REG_OUT=C_RST_VAL; new transactions accepted after release.
